// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: word type, RAM handshake state,
// arbiter grant state and the arbitration priority function.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Picks the next owner of the RAM port. The data side normally wins;
  // fetch_due lets a starved fetch jump the queue.
  function automatic arb_state_t arbitrate(input logic d_req,
                                           input logic i_req,
                                           input logic fetch_due);
    if (i_req && fetch_due) return GRANT_I;
    if (d_req)              return GRANT_D;
    if (i_req)              return GRANT_I;
    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the memory arbiter.
// Modport arb is the arbiter's view; modport tb drives the requesters and RAM.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // fetch side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  // load/store side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  // status
  logic      arb_err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and load/store.
// Registered grant FSM, combinational RAM drive and data return.
// Optional feature macro MEM_ARB_STREAK_EN: bounds the number of consecutive
// data completions while a fetch waits (MAX_DATA_STREAK, 1..7).
module mem_arbiter
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_STREAK_EN
#(
  parameter int unsigned MAX_DATA_STREAK = 4
)
`endif
(
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.arb   bus
);

  arb_state_t state_q, state_d;
  logic       arb_err_q;
  logic       d_req;
  logic       i_active, d_active;
  logic       i_done, d_done;
  logic       owner_err;
  logic       fetch_due;

  assign d_req     = bus.dREN | bus.dWEN;
  // The current owner still requesting; a dropped request aborts the grant.
  assign i_active  = (state_q == GRANT_I) & bus.iREN;
  assign d_active  = (state_q == GRANT_D) & d_req;
  assign i_done    = i_active & (bus.ramstate == ACCESS);
  assign d_done    = d_active & (bus.ramstate == ACCESS);
  assign owner_err = (i_active | d_active) & (bus.ramstate == ERROR);

`ifdef MEM_ARB_STREAK_EN
  logic [2:0] streak_q, streak_d;

  // Count data completions that happened while a fetch was waiting.
  always_comb begin
    streak_d = streak_q;
    if (!bus.iREN || i_done) begin
      streak_d = '0;
    end else if (d_done && (streak_q != 3'b111)) begin
      streak_d = streak_q + 3'd1;
    end
  end

  // Streak register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  // Use the post-update count so the fetch is granted right after the
  // completion that reaches the limit, not one data access later.
  assign fetch_due = (32'(streak_d) >= MAX_DATA_STREAK);
`else
  assign fetch_due = 1'b0;
`endif

  // Grant state register.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          arb_err_q <= 1'b0;
    else if (owner_err) arb_err_q <= 1'b1;
  end

  // Next-state: re-arbitrate on completion or abort, back off to IDLE on error.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = arbitrate(d_req, bus.iREN, fetch_due);
      GRANT_I: begin
        if (!bus.iREN || i_done)          state_d = arbitrate(d_req, bus.iREN, fetch_due);
        else if (bus.ramstate == ERROR)   state_d = IDLE;
      end
      GRANT_D: begin
        if (!d_req || d_done)             state_d = arbitrate(d_req, bus.iREN, fetch_due);
        else if (bus.ramstate == ERROR)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive from the active owner only; writes win over reads on d-side.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (i_active) begin
      bus.ramREN  = 1'b1;
      bus.ramaddr = bus.iaddr;
    end
    if (d_active) begin
      bus.ramREN   = bus.dREN & ~bus.dWEN;
      bus.ramWEN   = bus.dWEN;
      bus.ramaddr  = bus.daddr;
      bus.ramstore = bus.dstore;
    end
  end

  // Requester handshake: wait until own access completes; data passes through.
  always_comb begin
    bus.iwait   = bus.iREN & ~i_done;
    bus.dwait   = d_req & ~d_done;
    bus.iload   = bus.ramload;
    bus.dload   = bus.ramload;
    bus.arb_err = arb_err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written sequences
// for asynchronous reset and the fetch-starvation behaviour.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic CLK;
  logic nRST;
  int   n_vec;
  int   n_err;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.tb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       i_ren;
    word_t      iaddr;
    logic       d_ren;
    logic       d_wen;
    word_t      daddr;
    word_t      dstore;
    ramstate_t  rs;
    word_t      rload;
    arb_state_t e_state;
    logic       e_iwait;
    logic       e_dwait;
    logic       e_ren;
    logic       e_wen;
    word_t      e_addr;
    word_t      e_store;
    logic       e_err;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  initial begin
    int i_cnt;
    int d_cnt;
    n_vec = 0;
    n_err = 0;

    //           iREN iaddr        dREN dWEN daddr        dstore        rs      rload           state    iw dw ren wen addr         store         err
    vecs[0]  = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    L, L, L, L, 32'h0,        32'h0,        L};
    vecs[1]  = '{H, 32'h40,       L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    H, L, L, L, 32'h0,        32'h0,        L};
    vecs[2]  = '{H, 32'h40,       L, L, 32'h0,        32'h0,        ACCESS, 32'h2409_0001, GRANT_I, L, L, H, L, 32'h40,       32'h0,        L};
    vecs[3]  = '{L, 32'h40,       L, L, 32'h0,        32'h0,        FREE,   32'h0,         GRANT_I, L, L, L, L, 32'h0,        32'h0,        L};
    vecs[4]  = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    L, L, L, L, 32'h0,        32'h0,        L};
    vecs[5]  = '{H, 32'h40,       L, H, 32'h100,      32'hDEAD_BEEF, FREE,  32'h0,         IDLE,    H, H, L, L, 32'h0,        32'h0,        L};
    vecs[6]  = '{H, 32'h40,       L, H, 32'h100,      32'hDEAD_BEEF, BUSY,  32'h0,         GRANT_D, H, H, L, H, 32'h100,      32'hDEAD_BEEF, L};
    vecs[7]  = '{H, 32'h40,       L, H, 32'h100,      32'hDEAD_BEEF, ACCESS, 32'hCAFE_0000, GRANT_D, H, L, L, H, 32'h100,     32'hDEAD_BEEF, L};
    vecs[8]  = '{H, 32'h40,       L, L, 32'h100,      32'hDEAD_BEEF, FREE,  32'h0,         GRANT_D, H, L, L, L, 32'h0,        32'h0,        L};
    vecs[9]  = '{H, 32'h40,       L, L, 32'h0,        32'h0,        ACCESS, 32'h8C22_0004, GRANT_I, L, L, H, L, 32'h40,       32'h0,        L};
    vecs[10] = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         GRANT_I, L, L, L, L, 32'h0,        32'h0,        L};
    vecs[11] = '{L, 32'h0,        H, L, 32'h200,      32'h0,        FREE,   32'h0,         IDLE,    L, H, L, L, 32'h0,        32'h0,        L};
    vecs[12] = '{L, 32'h0,        H, L, 32'h200,      32'h0,        BUSY,   32'h0,         GRANT_D, L, H, H, L, 32'h200,      32'h0,        L};
    vecs[13] = '{L, 32'h0,        H, L, 32'h200,      32'h0,        BUSY,   32'h0,         GRANT_D, L, H, H, L, 32'h200,      32'h0,        L};
    vecs[14] = '{L, 32'h0,        H, L, 32'h200,      32'h0,        BUSY,   32'h0,         GRANT_D, L, H, H, L, 32'h200,      32'h0,        L};
    vecs[15] = '{L, 32'h0,        H, L, 32'h200,      32'h0,        ACCESS, 32'h1234_5678, GRANT_D, L, L, H, L, 32'h200,      32'h0,        L};
    vecs[16] = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         GRANT_D, L, L, L, L, 32'h0,        32'h0,        L};
    vecs[17] = '{L, 32'h0,        H, H, 32'h300,      32'h55,       FREE,   32'h0,         IDLE,    L, H, L, L, 32'h0,        32'h0,        L};
    vecs[18] = '{L, 32'h0,        H, H, 32'h300,      32'h55,       BUSY,   32'h0,         GRANT_D, L, H, L, H, 32'h300,      32'h55,       L};
    vecs[19] = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         GRANT_D, L, L, L, L, 32'h0,        32'h0,        L};
    vecs[20] = '{H, 32'h80,       L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    H, L, L, L, 32'h0,        32'h0,        L};
    vecs[21] = '{H, 32'h80,       L, L, 32'h0,        32'h0,        ERROR,  32'h0,         GRANT_I, H, L, H, L, 32'h80,       32'h0,        L};
    vecs[22] = '{H, 32'h80,       L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    H, L, L, L, 32'h0,        32'h0,        H};
    vecs[23] = '{H, 32'h80,       L, L, 32'h0,        32'h0,        ACCESS, 32'hAAAA_5555, GRANT_I, L, L, H, L, 32'h80,       32'h0,        H};
    vecs[24] = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         GRANT_I, L, L, L, L, 32'h0,        32'h0,        H};
    vecs[25] = '{L, 32'h0,        L, L, 32'h0,        32'h0,        FREE,   32'h0,         IDLE,    L, L, L, L, 32'h0,        32'h0,        H};

    // Power-on reset state.
    drive_idle();
    nRST = 1'b0;
    #3;
    check("rst_state",  32'(dut.state_q),   32'(IDLE));
    check("rst_ramren", 32'(bus.ramREN),    32'h0);
    check("rst_ramwen", 32'(bus.ramWEN),    32'h0);
    check("rst_err",    32'(bus.arb_err),   32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Table-driven vectors: drive after the rising edge, compare at the falling edge.
    for (int v = 0; v < 26; v++) begin
      @(posedge CLK);
      #1;
      bus.iREN     = vecs[v].i_ren;
      bus.iaddr    = vecs[v].iaddr;
      bus.dREN     = vecs[v].d_ren;
      bus.dWEN     = vecs[v].d_wen;
      bus.daddr    = vecs[v].daddr;
      bus.dstore   = vecs[v].dstore;
      bus.ramstate = vecs[v].rs;
      bus.ramload  = vecs[v].rload;
      @(negedge CLK);
      check($sformatf("v%0d_state", v),    32'(dut.state_q),  32'(vecs[v].e_state));
      check($sformatf("v%0d_iwait", v),    32'(bus.iwait),    32'(vecs[v].e_iwait));
      check($sformatf("v%0d_dwait", v),    32'(bus.dwait),    32'(vecs[v].e_dwait));
      check($sformatf("v%0d_ramren", v),   32'(bus.ramREN),   32'(vecs[v].e_ren));
      check($sformatf("v%0d_ramwen", v),   32'(bus.ramWEN),   32'(vecs[v].e_wen));
      check($sformatf("v%0d_ramaddr", v),  bus.ramaddr,       vecs[v].e_addr);
      check($sformatf("v%0d_ramstore", v), bus.ramstore,      vecs[v].e_store);
      check($sformatf("v%0d_err", v),      32'(bus.arb_err),  32'(vecs[v].e_err));
      check($sformatf("v%0d_iload", v),    bus.iload,         vecs[v].rload);
      check($sformatf("v%0d_dload", v),    bus.dload,         vecs[v].rload);
    end

    // Asynchronous reset in the middle of a busy store.
    @(posedge CLK);
    #1;
    drive_idle();
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h400;
    bus.dstore = 32'h77;
    @(posedge CLK);
    #1;
    bus.ramstate = BUSY;
    @(negedge CLK);
    check("mid_state",  32'(dut.state_q), 32'(GRANT_D));
    check("mid_ramwen", 32'(bus.ramWEN),  32'h1);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_state",  32'(dut.state_q), 32'(IDLE));
    check("arst_ramwen", 32'(bus.ramWEN),  32'h0);
    check("arst_err",    32'(bus.arb_err), 32'h0);
    drive_idle();
    @(negedge CLK);
    nRST = 1'b1;

    // Continuous fetch and load traffic with single-cycle RAM accesses.
    @(posedge CLK);
    #1;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h500;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h600;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0BAD_F00D;
    i_cnt = 0;
    d_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      logic exp_i;
      logic exp_d;
      logic act_i;
      logic act_d;
      @(negedge CLK);
`ifdef MEM_ARB_STREAK_EN
      exp_i = (k > 0) && (k % 5 == 0);
`else
      exp_i = 1'b0;
`endif
      exp_d = (k > 0) && !exp_i;
      act_i = bus.iREN & ~bus.iwait;
      act_d = bus.dREN & ~bus.dwait;
      if (act_i) i_cnt++;
      if (act_d) d_cnt++;
      check($sformatf("streak%0d_idone", k), 32'(act_i), 32'(exp_i));
      check($sformatf("streak%0d_ddone", k), 32'(act_d), 32'(exp_d));
    end
`ifdef MEM_ARB_STREAK_EN
    check("streak_i_total", 32'(i_cnt), 32'd5);
    check("streak_d_total", 32'(d_cnt), 32'd24);
`else
    check("streak_i_total", 32'(i_cnt), 32'd0);
    check("streak_d_total", 32'(d_cnt), 32'd29);
`endif
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
